uart_tx_mmio: RTL

//   Memory-mapped UART transmitter behind the data-memory address decoder; consumes the
//   TX write-enable strobe raised for address 0x10010030. Serialises 8N1 frames
//   (8E1 with parity option) on a single line, with a one-entry holding register so
//   the core can queue one byte while another is on the wire. Status word feeds the read-data mux.

---
 rtl/uart_tx_mmio.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a one-byte holding register and a sticky overrun flag.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit (8E1).
module uart_tx_mmio #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        ovr_clr,
    output logic        tx,
    output logic        tx_done,
    output logic [31:0] status_rdata
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic            overrun_q, overrun_d;
    logic            tx_q, tx_d;
    logic            bit_end, stop_end, busy;
    logic            unused_wr_hi;

    assign unused_wr_hi = ^wr_data[31:8];
    assign bit_end  = (cnt_q == CNT_MAX);
    assign stop_end = (state_q == S_STOP) && bit_end;
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun_d   = overrun_q;

        if (busy) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

        // Set beats clear when both happen in the same cycle.
        if (ovr_clr) overrun_d = 1'b0;
        if (wr_en && hold_full_q) overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    shift_d = wr_data[7:0];
                    state_d = S_START;
                end
            end
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end) begin
                    // Rotate rather than zero-fill so ^shift stays the frame's parity.
                    shift_d   = {shift_q[0], shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = S_START;
                    end else if (wr_en) begin
                        shift_d = wr_data[7:0];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en && busy && !hold_full_q && !stop_end) begin
            hold_d      = wr_data[7:0];
            hold_full_d = 1'b1;
        end

        // Line level follows the next state so tx changes on the same edge as the state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = ^shift_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            overrun_q   <= overrun_d;
            tx_q        <= tx_d;
        end
    end

    assign tx           = tx_q;
    assign tx_done      = stop_end;
    assign status_rdata = {29'b0, overrun_q, hold_full_q, busy};
endmodule
